voc_cal_sequencer: RTL
======================

Name: voc_cal_sequencer

Overview:
Controller for 0 V offset calibration of the voltmeter ADC path. It sequences calibration on power-up, on request and (optionally) on a periodic timer: settle, accumulate, average, commit. It holds the committed offset and produces offset-corrected signed samples for the display/scaling logic downstream. It sits between the ADC sample interface and the voltage-to-BCD path.

Parameters:
WIDTH, 8, ADC sample width
LOG2_N, 10, log2 of averaged sample count (N = 2^LOG2_N)
SETTLE_SMP, 1023, ADC strobes discarded before accumulation (0 allowed)
RECAL_PERIOD, 50_000_000, clk cycles between automatic recalibrations (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ad_data  in  WIDTH  ADC sample, unsigned
ad_valid  in  1  one-cycle strobe, ad_data valid
cal_req  in  1  recalibration request, held high until cal_ack
cal_ack  out  1  one-cycle pulse, request accepted
cal_busy  out  1  high in SETTLE/ACCUM/UPDATE
cal_done  out  1  one-cycle pulse, new offset committed
cal_valid  out  1  level, at least one offset committed since reset
voc_data  out  WIDTH  committed 0 V offset code
volt_data  out  WIDTH+1  signed ad_data - voc_data, registered
volt_valid  out  1  strobe qualifying volt_data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the only clock. All outputs are 0 during reset. State is SETTLE, and counters and sum are cleared. Power-up calibration starts automatically on the first clk edge after release.
- States:
  - IDLE: wait.
  - SETTLE: count ad_valid strobes. After SETTLE_SMP strobes, go to ACCUM. With SETTLE_SMP=0, go straight to ACCUM.
  - ACCUM: add ad_data on each ad_valid. After exactly N strobes, go to UPDATE.
  - UPDATE: one cycle. Commit voc_data, pulse cal_done, set cal_valid=1, go to IDLE.
- Only ad_valid strobes count. Cycles without ad_valid do not advance SETTLE or ACCUM.
- Sum width is WIDTH+LOG2_N and must not overflow. The sum is cleared on entry to SETTLE.
- Averaging: voc_data = sum >> LOG2_N, rounded half-up. Add 1 if sum[LOG2_N-1]=1. The result always fits in WIDTH bits.
- Request handshake:
  - cal_req is sampled only in IDLE. cal_ack pulses in the same cycle the FSM leaves IDLE for SETTLE.
  - While busy, cal_req gets no ack and is not queued; the requester keeps holding it.
  - cal_req still high one cycle after the ack starts a new calibration only once the FSM is back in IDLE.
- During recalibration, voc_data and cal_valid keep their previous values until UPDATE. Correction continues using the old offset.
- Correction:
  - When cal_valid=1 and ad_valid=1: volt_data <= {1'b0,ad_data} - {1'b0,voc_data} (two's complement, WIDTH+1 bits), and volt_valid <= 1 on the next cycle. Latency is 1 clk.
  - When cal_valid=0, volt_valid stays 0 and volt_data holds its value.
  - In the UPDATE cycle, the correction uses the old voc_data. The new offset applies from the next cycle.
- Reset mid-operation: any state aborts. The committed offset is lost, and power-up calibration restarts.

Optional Feature:
- Macro VOC_PERIODIC_RECAL_EN.
- Defined:
  - A clk-cycle timer counts while in IDLE and clears on leaving IDLE. On reaching RECAL_PERIOD-1 it self-triggers SETTLE. There is no cal_ack for a self-trigger.
  - If cal_req and timer expiry coincide, cal_req wins and cal_ack pulses.
- Not defined: no timer logic. Calibration runs only at power-up and on cal_req. RECAL_PERIOD is unused.

Decomposition:
- Shared package/include voc_cal_pkg:
  - state encoding: IDLE, SETTLE, ACCUM, UPDATE
  - localparams SUM_W=WIDTH+LOG2_N, CNT_W=max($clog2(SETTLE_SMP+1), LOG2_N+1)
  - timer width derived from RECAL_PERIOD
- One natural sub-module, voc_avg_accum: clear, add-on-strobe accumulator plus round-half-up divide. It outputs the rounded average combinationally.
- The FSM, handshake and correction stay in the top.

Test Plan:
- Bench setting: WIDTH=8, LOG2_N=4, SETTLE_SMP=3, ad_valid every cycle unless stated.
- Power-up with ad_data=0x80 constant: cal_busy high from the first edge; cal_done after 3+16 strobes plus the UPDATE cycle; voc_data=0x80, cal_valid=1, cal_ack never pulses.
- Rounding, 8×10 then 8×11 (sum 168): voc_data=11. 15×10 then 1×17 (sum 167): voc_data=10.
- Correction, voc_data=0x80, ad_data=0x7C strobe: next cycle volt_data=9'h1FC (−4), volt_valid=1. ad_data=0xFF gives 9'h07F. Before the first cal_valid, volt_valid stays 0.
- Handshake:
  - cal_req raised mid-ACCUM: no ack until IDLE, then a single cal_ack pulse.
  - During recal, voc_data is unchanged until cal_done. With ad_valid every 3rd cycle, only strobes are counted (19 strobes total).
- Reset asserted mid-ACCUM: all outputs 0 immediately (asynchronous). After release, a full fresh calibration runs and cal_done arrives after 19 strobes plus 1 cycle.
- With VOC_PERIODIC_RECAL_EN and RECAL_PERIOD=50: an automatic recal starts 50 cycles after entering IDLE, without cal_ack. cal_req in the expiry cycle gives cal_ack=1.

Source files
------------

// File: rtl/voc_cal_pkg.sv
// Shared types and width helpers for the 0 V offset calibration sequencer.
// The sizing helpers are functions because the widths depend on module parameters.
package voc_cal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_UPDATE = 2'd3
  } voc_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter covers both the settle count and the N accumulated strobes.
  function automatic int cnt_width(input int settle_smp, input int log2_n);
    return max2($clog2(settle_smp + 1), log2_n + 1);
  endfunction

  function automatic int timer_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/voc_avg_accum.sv
// Strobe-driven accumulator with round-half-up divide by 2^LOG2_N.
// The sum is WIDTH+LOG2_N wide, so N full-scale samples cannot overflow it.
module voc_avg_accum #(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] avg
);

  localparam int SUM_W = WIDTH + LOG2_N;

  logic [SUM_W-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + {{LOG2_N{1'b0}}, din};
    end
  end

  // A set half-bit can only round up when the quotient is below full scale,
  // so the WIDTH-bit result never wraps.
  assign avg = sum[SUM_W-1:LOG2_N] + WIDTH'(sum[LOG2_N-1]);

endmodule

// File: rtl/voc_cal_sequencer.sv
// 0 V offset calibration controller: settle, accumulate, average, commit, then
// offset-correct ADC samples. Optional periodic recalibration: VOC_PERIODIC_RECAL_EN.
module voc_cal_sequencer
  import voc_cal_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LOG2_N       = 10,
  parameter int SETTLE_SMP   = 1023,
  parameter int RECAL_PERIOD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ad_data,
  input  logic             ad_valid,
  input  logic             cal_req,
  output logic             cal_ack,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_valid,
  output logic [WIDTH-1:0] voc_data,
  output logic [WIDTH:0]   volt_data,
  output logic             volt_valid,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = cnt_width(SETTLE_SMP, LOG2_N);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_SMP > 0) ? SETTLE_SMP - 1 : 0);
  localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((1 << LOG2_N) - 1);

  if (LOG2_N < 1 || RECAL_PERIOD < 1) begin : g_param_check
    $error("voc_cal_sequencer: LOG2_N and RECAL_PERIOD must be at least 1");
  end

  voc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] avg;
  logic             tmr_expire;
  logic             start;

  assign start     = (state == ST_IDLE) && (cal_req || tmr_expire);
  assign dbg_state = state;

`ifdef VOC_PERIODIC_RECAL_EN
  localparam int TMR_W = timer_width(RECAL_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RECAL_PERIOD - 1);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != ST_IDLE || start) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign tmr_expire = (state == ST_IDLE) && (timer == TMR_LAST);
`else
  assign tmr_expire = 1'b0;
`endif

  voc_avg_accum #(
    .WIDTH (WIDTH),
    .LOG2_N(LOG2_N)
  ) u_accum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .add  ((state == ST_ACCUM) && ad_valid),
    .din  (ad_data),
    .avg  (avg)
  );

  // Handshake: cal_req is a level held by the requester; it is only sampled
  // in IDLE, and cal_ack is a one-cycle pulse visible in the first SETTLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      cnt        <= '0;
      cal_ack    <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_valid  <= 1'b0;
      voc_data   <= '0;
      volt_data  <= '0;
      volt_valid <= 1'b0;
    end else begin
      cal_ack  <= 1'b0;
      cal_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETTLE;
            cnt      <= '0;
            cal_busy <= 1'b1;
            cal_ack  <= cal_req;
          end
        end
        ST_SETTLE: begin
          cal_busy <= 1'b1;
          if (SETTLE_SMP == 0) begin
            state <= ST_ACCUM;
            cnt   <= '0;
          end else if (ad_valid) begin
            if (cnt == SETTLE_LAST) begin
              state <= ST_ACCUM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          cal_busy <= 1'b1;
          if (ad_valid) begin
            if (cnt == ACCUM_LAST) begin
              state <= ST_UPDATE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          voc_data  <= avg;
          cal_done  <= 1'b1;
          cal_valid <= 1'b1;
          cal_busy  <= 1'b0;
        end
      endcase

      // Uses the registered offset, so the UPDATE cycle still corrects with the old value.
      if (cal_valid && ad_valid) begin
        volt_data  <= {1'b0, ad_data} - {1'b0, voc_data};
        volt_valid <= 1'b1;
      end else begin
        volt_valid <= 1'b0;
      end
    end
  end

endmodule
